// File: rtl/uart_alu_frame_ctrl.sv
// UART-to-ALU frame controller: assembles operand A, operand B and an opcode from
// received bytes, commits them to the ALU, then transmits the result LSB byte first.
module uart_alu_frame_ctrl #(
  parameter int NBIT_DATA_LEN  = 8,
  parameter int NBIT_OP_LEN    = 6,
  parameter int N_BYTES        = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int NB_WORD       = NBIT_DATA_LEN * N_BYTES
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rx_done_tick,
  input  logic [NBIT_DATA_LEN-1:0] rx_data_in,
  input  logic                     tx_done_tick,
  input  logic [NB_WORD-1:0]       alu_result,
  output logic [NB_WORD-1:0]       a_out,
  output logic [NB_WORD-1:0]       b_out,
  output logic [NBIT_OP_LEN-1:0]   op_out,
  output logic                     tx_start,
  output logic [NBIT_DATA_LEN-1:0] tx_data,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [7:0]               frame_count
);

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {RX_A, RX_B, RX_OP, LATCH, TX_SEND, TX_WAIT} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     rx_prev_q, tx_prev_q;
  logic [NB_WORD-1:0]       a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [NB_WORD-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
  logic [NBIT_OP_LEN-1:0]   op_q, op_d;
  logic                     tx_start_q, tx_start_d, terr_q, terr_d;
  logic [NBIT_DATA_LEN-1:0] tx_data_q, tx_data_d;
  logic [7:0]               fc_q, fc_d;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic                     rx_ev, tx_ev, busy_w, tmo_run, expire;
  logic [31:0]              boff;

  // Level flags from the UART are converted to single-cycle events here.
  assign rx_ev   = rx_done_tick & ~rx_prev_q;
  assign tx_ev   = tx_done_tick & ~tx_prev_q;
  assign busy_w  = (state_q != RX_A) || (idx_q != '0);
  assign tmo_run = busy_w && (state_q inside {RX_A, RX_B, RX_OP});
  assign expire  = tmo_run && !rx_ev && (tmo_q == TMO_LAST);
  assign boff    = 32'(idx_q) * 32'(NBIT_DATA_LEN);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    res_d      = res_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    terr_d     = 1'b0;
    fc_d       = fc_q;
    tmo_d      = (tmo_run && !rx_ev) ? tmo_q + TMO_W'(1) : '0;
    case (state_q)
      RX_A: if (rx_ev) begin
        a_sh_d[boff +: NBIT_DATA_LEN] = rx_data_in;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = RX_B;
        end else idx_d = idx_q + IDX_W'(1);
      end
      RX_B: if (rx_ev) begin
        b_sh_d[boff +: NBIT_DATA_LEN] = rx_data_in;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          state_d = RX_OP;
        end else idx_d = idx_q + IDX_W'(1);
      end
      RX_OP: if (rx_ev) begin
        a_d     = a_sh_q;
        b_d     = b_sh_q;
        op_d    = rx_data_in[NBIT_OP_LEN-1:0];
        state_d = LATCH;
      end
      LATCH: begin
        res_d   = alu_result;
        state_d = TX_SEND;
      end
      TX_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = res_q[boff +: NBIT_DATA_LEN];
        state_d    = TX_WAIT;
      end
      TX_WAIT: if (tx_ev) begin
        if (idx_q != IDX_LAST) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = TX_SEND;
        end else begin
          idx_d   = '0;
          fc_d    = fc_q + 8'd1;
          state_d = RX_A;
        end
      end
      default: state_d = RX_A;
    endcase
    // A stalled frame is dropped; committed operands keep their last values.
    if (expire) begin
      terr_d  = 1'b1;
      state_d = RX_A;
      idx_d   = '0;
      a_sh_d  = '0;
      b_sh_d  = '0;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RX_A;
      idx_q      <= '0;
      rx_prev_q  <= 1'b0;
      tx_prev_q  <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      res_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      terr_q     <= 1'b0;
      fc_q       <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rx_prev_q  <= rx_done_tick;
      tx_prev_q  <= tx_done_tick;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      res_q      <= res_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      terr_q     <= terr_d;
      fc_q       <= fc_d;
      tmo_q      <= tmo_d;
    end
  end

  assign a_out       = a_q;
  assign b_out       = b_q;
  assign op_out      = op_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign busy        = busy_w;
  assign timeout_err = terr_q;
  assign frame_count = fc_q;

endmodule
